// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets two cores share one combinational ALU.
// Each operation goes through three states: accept in IDLE, execute for one cycle, then hold the response until the core takes it.
module alu_arbiter #(
    parameter int W_CPU    = 32,
    parameter int W_OPCODE = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*W_OPCODE-1:0] req_op,
    input  logic [2*W_CPU-1:0]    req_a,
    input  logic [2*W_CPU-1:0]    req_b,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [W_CPU-1:0]      rsp_r,
    output logic                  rsp_overflow,
    output logic                  rsp_zero,
    output logic [W_OPCODE-1:0]   alu_op,
    output logic [W_CPU-1:0]      alu_a,
    output logic [W_CPU-1:0]      alu_b,
    input  logic [W_CPU-1:0]      alu_r,
    input  logic                  alu_overflow,
    input  logic                  alu_zero,
    output logic                  busy,
    output logic                  grant_id
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_id_q, grant_id_d;
    logic [W_OPCODE-1:0] op_q, op_d;
    logic [W_CPU-1:0]    a_q, a_d;
    logic [W_CPU-1:0]    b_q, b_d;
    logic [W_CPU-1:0]    r_q, r_d;
    logic                ovf_q, ovf_d;
    logic                zero_q, zero_d;
    logic                win;
    logic                accept;

    // On a tie the core that was not served last wins.
    always_comb begin
        win = 1'b0;
        case (req_valid)
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_grant_q;
            default: win = 1'b0;
        endcase
        accept    = (state_q == IDLE) && req_valid[win];
        req_ready = 2'b00;
        if (accept) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        r_d          = r_q;
        ovf_d        = ovf_q;
        zero_d       = zero_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d       = win ? req_op[2*W_OPCODE-1:W_OPCODE] : req_op[W_OPCODE-1:0];
                    a_d        = win ? req_a[2*W_CPU-1:W_CPU] : req_a[W_CPU-1:0];
                    b_d        = win ? req_b[2*W_CPU-1:W_CPU] : req_b[W_CPU-1:0];
                    grant_id_d = win;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                r_d     = alu_r;
                ovf_d   = alu_overflow;
                zero_d  = alu_zero;
                state_d = RESP;
            end
            RESP: begin
                // Only the granted core's rsp_ready matters here.
                if (rsp_ready[grant_id_q]) begin
                    last_grant_d = grant_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            r_q          <= '0;
            ovf_q        <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            r_q          <= r_d;
            ovf_q        <= ovf_d;
            zero_q       <= zero_d;
        end
    end

    assign alu_op       = op_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign rsp_r        = r_q;
    assign rsp_overflow = ovf_q;
    assign rsp_zero     = zero_q;
    assign rsp_valid    = (state_q == RESP) ? (grant_id_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy         = (state_q != IDLE);
    assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a small ALU model stands in for the shared ALU.
module tb_alu_arbiter;

    localparam int W_CPU    = 32;
    localparam int W_OPCODE = 6;
    localparam logic [W_OPCODE-1:0] OP_ADD  = 6'h20;
    localparam logic [W_OPCODE-1:0] OP_SUB  = 6'h22;
    localparam logic [W_OPCODE-1:0] OP_OR   = 6'h25;
    localparam logic [W_OPCODE-1:0] OP_ADDI = 6'h08;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [1:0]            reqValid;
    logic [1:0]            reqReady;
    logic [2*W_OPCODE-1:0] reqOp;
    logic [2*W_CPU-1:0]    reqA;
    logic [2*W_CPU-1:0]    reqB;
    logic [1:0]            rspValid;
    logic [1:0]            rspReady;
    logic [W_CPU-1:0]      rspR;
    logic                  rspOverflow;
    logic                  rspZero;
    logic [W_OPCODE-1:0]   aluOp;
    logic [W_CPU-1:0]      aluA;
    logic [W_CPU-1:0]      aluB;
    logic [W_CPU-1:0]      aluR;
    logic                  aluOverflow;
    logic                  aluZero;
    logic                  busy;
    logic                  grantId;

    int compareCount = 0;
    int failCount    = 0;

    alu_arbiter #(.W_CPU(W_CPU), .W_OPCODE(W_OPCODE)) dut (
        .clk(clk), .reset(reset),
        .req_valid(reqValid), .req_ready(reqReady),
        .req_op(reqOp), .req_a(reqA), .req_b(reqB),
        .rsp_valid(rspValid), .rsp_ready(rspReady),
        .rsp_r(rspR), .rsp_overflow(rspOverflow), .rsp_zero(rspZero),
        .alu_op(aluOp), .alu_a(aluA), .alu_b(aluB),
        .alu_r(aluR), .alu_overflow(aluOverflow), .alu_zero(aluZero),
        .busy(busy), .grant_id(grantId)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared ALU: signed overflow on add/sub, isZero on the result.
    always_comb begin
        aluR        = '0;
        aluOverflow = 1'b0;
        case (aluOp)
            OP_ADD, OP_ADDI: begin
                aluR        = aluA + aluB;
                aluOverflow = (aluA[31] == aluB[31]) && (aluR[31] != aluA[31]);
            end
            OP_SUB: begin
                aluR        = aluA - aluB;
                aluOverflow = (aluA[31] != aluB[31]) && (aluR[31] != aluA[31]);
            end
            OP_OR:   aluR = aluA | aluB;
            default: aluR = '0;
        endcase
        aluZero = (aluR == '0);
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid,
                                 input logic [W_OPCODE-1:0] op0, input logic [W_CPU-1:0] a0, input logic [W_CPU-1:0] b0,
                                 input logic [W_OPCODE-1:0] op1, input logic [W_CPU-1:0] a1, input logic [W_CPU-1:0] b1,
                                 input logic [1:0] rspRdy);
        reqValid = valid;
        reqOp    = {op1, op0};
        reqA     = {a1, a0};
        reqB     = {b1, b0};
        rspReady = rspRdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(2'b00, '0, '0, '0, '0, '0, '0, 2'b00);
        nextCycle();
        nextCycle();
        reset = 1'b0;
        repeat (5) nextCycle();
        checkOutput("rst_req_ready", 64'(reqReady), 64'h0);
        checkOutput("rst_rsp_valid", 64'(rspValid), 64'h0);
        checkOutput("rst_busy", 64'(busy), 64'h0);
        checkOutput("rst_rsp_r", 64'(rspR), 64'h0);
        checkOutput("rst_grant_id", 64'(grantId), 64'h0);
        checkOutput("rst_alu_a", 64'(aluA), 64'h0);

        $display("[TB] core 0 alone: ADD 5+7");
        applyStimulus(2'b01, OP_ADD, 32'd5, 32'd7, '0, '0, '0, 2'b11);
        checkOutput("add_req_ready", 64'(reqReady), 64'h1);
        nextCycle();
        applyStimulus(2'b00, OP_ADD, 32'd5, 32'd7, '0, '0, '0, 2'b11);
        checkOutput("add_exec_busy", 64'(busy), 64'h1);
        checkOutput("add_exec_alu_a", 64'(aluA), 64'd5);
        checkOutput("add_exec_alu_b", 64'(aluB), 64'd7);
        checkOutput("add_exec_alu_op", 64'(aluOp), 64'(OP_ADD));
        checkOutput("add_exec_rsp_valid", 64'(rspValid), 64'h0);
        nextCycle();
        checkOutput("add_rsp_valid", 64'(rspValid), 64'h1);
        checkOutput("add_rsp_r", 64'(rspR), 64'd12);
        checkOutput("add_rsp_zero", 64'(rspZero), 64'h0);
        checkOutput("add_rsp_ovf", 64'(rspOverflow), 64'h0);
        nextCycle();
        checkOutput("add_idle_busy", 64'(busy), 64'h0);
        checkOutput("add_idle_rsp_valid", 64'(rspValid), 64'h0);

        $display("[TB] both cores requesting continuously from reset");
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        applyStimulus(2'b11, OP_SUB, 32'd9, 32'd9, OP_OR, 32'hF0, 32'h0F, 2'b11);
        for (int i = 0; i < 4; i++) begin
            logic core;
            core = 1'(i % 2);
            checkOutput($sformatf("rr%0d_req_ready", i), 64'(reqReady), core ? 64'h2 : 64'h1);
            nextCycle();
            checkOutput($sformatf("rr%0d_grant_id", i), 64'(grantId), 64'(core));
            nextCycle();
            checkOutput($sformatf("rr%0d_rsp_valid", i), 64'(rspValid), core ? 64'h2 : 64'h1);
            checkOutput($sformatf("rr%0d_rsp_r", i), 64'(rspR), core ? 64'hFF : 64'h0);
            checkOutput($sformatf("rr%0d_rsp_zero", i), 64'(rspZero), core ? 64'h0 : 64'h1);
            nextCycle();
        end

        $display("[TB] core 1 ADDI overflow with stalled response");
        applyStimulus(2'b10, OP_ADD, 32'd5, 32'd5, OP_ADDI, 32'h7FFF_FFFF, 32'd1, 2'b00);
        checkOutput("ovf_req_ready", 64'(reqReady), 64'h2);
        nextCycle();
        applyStimulus(2'b01, OP_ADD, 32'd5, 32'd5, OP_ADDI, 32'h7FFF_FFFF, 32'd1, 2'b00);
        checkOutput("ovf_exec_req_ready", 64'(reqReady), 64'h0);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("ovf_w%0d_rsp_valid", i), 64'(rspValid), 64'h2);
            checkOutput($sformatf("ovf_w%0d_rsp_r", i), 64'(rspR), 64'h8000_0000);
            checkOutput($sformatf("ovf_w%0d_rsp_ovf", i), 64'(rspOverflow), 64'h1);
            checkOutput($sformatf("ovf_w%0d_req_ready", i), 64'(reqReady), 64'h0);
            nextCycle();
        end
        applyStimulus(2'b00, OP_ADD, 32'd5, 32'd5, OP_ADDI, 32'h7FFF_FFFF, 32'd1, 2'b01);
        nextCycle();
        checkOutput("ovf_wrong_ready_ignored", 64'(rspValid), 64'h2);
        applyStimulus(2'b00, OP_ADD, 32'd5, 32'd5, OP_ADDI, 32'h7FFF_FFFF, 32'd1, 2'b10);
        nextCycle();
        checkOutput("ovf_done_rsp_valid", 64'(rspValid), 64'h0);
        checkOutput("ovf_done_busy", 64'(busy), 64'h0);

        $display("[TB] short-lived core 0 request during RESP");
        applyStimulus(2'b10, '0, '0, '0, OP_ADD, 32'd1, 32'd2, 2'b00);
        nextCycle();
        applyStimulus(2'b00, '0, '0, '0, OP_ADD, 32'd1, 32'd2, 2'b00);
        nextCycle();
        applyStimulus(2'b01, OP_ADD, 32'd100, 32'd100, OP_ADD, 32'd1, 32'd2, 2'b00);
        checkOutput("blip_req_ready", 64'(reqReady), 64'h0);
        nextCycle();
        applyStimulus(2'b00, OP_ADD, 32'd100, 32'd100, OP_ADD, 32'd1, 32'd2, 2'b10);
        checkOutput("blip_rsp_r", 64'(rspR), 64'd3);
        checkOutput("blip_alu_a", 64'(aluA), 64'd1);
        checkOutput("blip_rsp_valid", 64'(rspValid), 64'h2);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("blip_idle_busy", 64'(busy), 64'h0);
        checkOutput("blip_grant_id", 64'(grantId), 64'h1);
        checkOutput("blip_idle_rsp_valid", 64'(rspValid), 64'h0);

        $display("[TB] reset during EXEC");
        applyStimulus(2'b01, OP_ADD, 32'd2, 32'd3, '0, '0, '0, 2'b11);
        nextCycle();
        checkOutput("rexec_busy_before", 64'(busy), 64'h1);
        applyStimulus(2'b00, OP_ADD, 32'd2, 32'd3, '0, '0, '0, 2'b11);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        checkOutput("rexec_busy", 64'(busy), 64'h0);
        checkOutput("rexec_rsp_valid", 64'(rspValid), 64'h0);
        checkOutput("rexec_rsp_r", 64'(rspR), 64'h0);
        checkOutput("rexec_alu_a", 64'(aluA), 64'h0);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            checkOutput($sformatf("rexec_c%0d_rsp_valid", i), 64'(rspValid), 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between the two cores of the dual-core processor.
- Each core issues ALU requests over a valid/ready handshake. The arbiter grants one core at a time, round-robin.
- The granted request's operands are registered and driven onto the shared ALU. The ALU outputs are captured into a result register.
- The result is returned to the granted core over a valid/ready response handshake. Sits between both cores' execute stages and the one ALU instance.

Parameters:
- W_CPU, 32, datapath width; matches `W_CPU.
- W_OPCODE, 6, ALU operation code width; matches `W_OPCODE.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  bit i: core i presents a request.
- req_ready  out  2  bit i: core i's request accepted this cycle.
- req_op  in  2*W_OPCODE  core i opcode at [i*W_OPCODE +: W_OPCODE].
- req_a  in  2*W_CPU  core i operand A at [i*W_CPU +: W_CPU].
- req_b  in  2*W_CPU  core i operand B, same packing.
- rsp_valid  out  2  bit i: response for core i available.
- rsp_ready  in  2  bit i: core i consumes the response.
- rsp_r  out  W_CPU  captured ALU result.
- rsp_overflow  out  1  captured ALU overflow.
- rsp_zero  out  1  captured ALU isZero.
- alu_op  out  W_OPCODE  to shared ALU alu_op.
- alu_a  out  W_CPU  to shared ALU A.
- alu_b  out  W_CPU  to shared ALU B.
- alu_r  in  W_CPU  from shared ALU R.
- alu_overflow  in  1  from shared ALU overflow.
- alu_zero  in  1  from shared ALU isZero.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  1  index of the currently or last granted core.

Behaviour:
- Reset is synchronous: on any rising clk with reset=1, the block is initialised as follows:
  - state=IDLE, last_grant=1 (core 0 wins the first tie), grant_id=0.
  - Operand registers (op, a, b) = 0; rsp_r=0, rsp_overflow=0, rsp_zero=0.
  - rsp_valid=00, req_ready=00, busy=0.
- Reset mid-operation (EXEC or RESP): the in-flight operation is dropped with no response, and the state returns to IDLE.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant selection (combinational):
  - Only one req_valid bit set: that core wins.
  - Both set: the core != last_grant wins.
  - req_ready[win]=1 only in IDLE with req_valid[win]=1; the other bit is 0.
  - On handshake, latch req_op/req_a/req_b of win, set grant_id=win, go to EXEC.
  - No request: stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_op/alu_a/alu_b carry the latched operands (always driven from the operand registers, in every state).
  - At the clock edge, capture alu_r/alu_overflow/alu_zero into the rsp_* registers, then go to RESP.
- RESP:
  - rsp_valid[grant_id]=1; the other bit is 0. rsp_r/rsp_overflow/rsp_zero stay stable while waiting.
  - When rsp_ready[grant_id]=1: set last_grant=grant_id, go to IDLE; rsp_valid drops the next cycle.
  - rsp_ready of the non-granted core is ignored.
- Timing:
  - Accept at edge T; rsp_valid high from cycle T+2.
  - Minimum 3 cycles per operation; no new request is accepted outside IDLE (req_ready=00).
- Fairness: with both cores continuously requesting, grants strictly alternate (0,1,0,1,...). Maximum wait for any core is one other operation.
- Handshake rules: a request may be withdrawn before it is accepted, with no side effect. req_* inputs are sampled only on the accept edge.
- Arithmetic: the block adds no arithmetic and no width conversion; ALU outputs pass through unmodified.

Test Plan:
- Reset, then idle 5 cycles -> req_ready=00, rsp_valid=00, busy=0, rsp_r=0, grant_id=0.
- Core 0 alone, `F_ADD, A=5, B=7, rsp_ready=1 held -> accepted at T; rsp_valid=01 at T+2 with rsp_r=12, rsp_zero=0; IDLE at T+3.
- Both cores request continuously from reset (core 0 `F_SUB 9-9, core 1 `F_OR 0xF0|0x0F) -> grants in order 0,1,0,1. Core 0 gets rsp_r=0, rsp_zero=1; core 1 gets rsp_r=0xFF.
- Core 1 `ADDI A=0x7FFFFFFF, B=1, rsp_ready held low 4 cycles -> rsp_valid=10 and rsp_r=0x80000000, rsp_overflow=1 stable all 4 cycles. req_ready stays 00 despite core 0 requesting.
- Reset asserted during EXEC -> next cycle state=IDLE, rsp_valid=00, and no response is ever issued for that operation.
- Core 0 raises req_valid for 1 cycle while the block is in RESP, then drops it -> never accepted; no side effects on rsp_* outputs.
